rate_tick_gen: RTL and testbench
================================

// Module: rate_tick_gen
// PURPOSE
//   Upstream timebase for the decimal counter/display path. Produces a one-cycle
//   enable pulse (o_tick) and a square-wave o_CLK at one of four rates chosen by
//   the contral switches.
//   Switch input is synchronised. A rate change takes effect only on a period
//   boundary, so the consumer never sees a runt or stretched period.
// PARAMETERS
//   DIV0   100_000_000  clock cycles per period, contral=2'b00 (1 Hz @100 MHz)
//   DIV1    50_000_000  cycles per period, contral=2'b01 (2 Hz)
//   DIV2    25_000_000  cycles per period, contral=2'b10 (4 Hz)
//   DIV3    10_000_000  cycles per period, contral=2'b11 (10 Hz)
//   CW      $clog2(max DIVn)  period counter width
// PORTS
//   CLK      in   1  system clock; the only clock
//   rst_n    in   1  asynchronous, active-low reset
//   contral  in   2  rate select, asynchronous (slide switches)
//   o_tick   out  1  1-cycle pulse, once per period, registered
//   o_CLK    out  1  50%-duty divided clock, registered, same period as o_tick
//   i_pause  in   1  only when RATE_TICK_PAUSE_EN is defined
// BEHAVIOUR
//   Reset: cnt=0, sel_act=2'b00, sync flops=0, o_tick=0, o_CLK=0.
//     All registers clear immediately on rst_n low.
//   Sync: contral passes through a 2-FF synchroniser -> sel_sync (2-cycle latency).
//   Counting: D = DIV[sel_act]; cnt runs 0..D-1.
//     At cnt==D-1: cnt<=0, o_tick<=1 next cycle, otherwise o_tick<=0.
//   o_CLK: set to 1 when cnt goes D/2-1 -> D/2; cleared to 0 on the wrap.
//     The rising edge of o_CLK therefore sits mid-period.
//   Rate change: sel_act<=sel_sync only on the wrap cycle (cnt==D-1).
//     The current period always completes at the old rate.
//     The next period uses the new D in full.
//     A switch toggled and restored within one period has no effect.
//   Divisors: every DIVn must be even and >=2; elaboration fails otherwise.
//   Width: compare cnt against D-1 held at CW bits; no truncation allowed.
//   Reset mid-period: the count restarts from 0 at DIV0. No tick on release.
//     The first tick arrives DIV0 cycles after rst_n deasserts.
// CONFIGURATION
//   RATE_TICK_PAUSE_EN defined:
//     i_pause is added and passes through its own 2-FF synchroniser.
//     While paused_sync=1: cnt holds, o_tick=0, o_CLK holds its level,
//     and sel_act does not update.
//     On resume, counting continues from the held cnt with no extra tick.
//   RATE_TICK_PAUSE_EN undefined:
//     There is no i_pause port and the counter free-runs.
// STRUCTURE
//   rate_tick_pkg: the 2-bit rate_sel_t typedef, the DIV table function
//     (sel -> divisor), and the CW computation.
//   sync_2ff: a reusable 2-flop synchroniser (parameter W).
//     Instantiated for contral, and for i_pause when RATE_TICK_PAUSE_EN is defined.
//   The counter, tick and o_CLK logic live in rate_tick_gen itself.
// TESTING (sim overrides: DIV0=4 DIV1=6 DIV2=8 DIV3=10)
//   1 Reset: rst_n=0 for 3 cycles, then released with contral=00.
//     -> o_tick,o_CLK=0 during reset; the first o_tick is exactly 4 cycles after
//     release, then every 4 cycles; o_CLK high 2 cycles, low 2 cycles.
//   2 Rate sweep: hold each contral value for 5 periods.
//     -> o_tick spacing is 4/6/8/10 cycles and o_CLK high time is 2/3/4/5 cycles.
//   3 Mid-period change: contral 00->11 at cnt==1.
//     -> the current period still ends 4 cycles after the previous tick;
//     subsequent spacing is 10.
//   4 Glitch: with contral=11, pulse contral to 00 for 1 cycle mid-period.
//     -> tick spacing stays 10 throughout.
//   5 Async reset mid-period: rst_n=0 between clock edges at cnt==5 with sel=11.
//     -> outputs go 0 without waiting for a clock edge; after release the rate
//     is DIV0 and the first tick comes at 4 cycles.
//   6 (RATE_TICK_PAUSE_EN) Pause: assert i_pause for 7 cycles at cnt==2, sel=00.
//     -> no tick while paused and o_CLK frozen; after the sync delay the next
//     tick arrives 2 cycles after counting resumes.

Source files
------------

// File: rtl/rate_tick_pkg.sv
// rate_tick_pkg: rate-select type, divisor lookup and period-counter width for rate_tick_gen.
package rate_tick_pkg;
  typedef logic [1:0] rate_sel_t;
  function automatic int unsigned div_of(rate_sel_t s, int unsigned d0, int unsigned d1,
                                         int unsigned d2, int unsigned d3);
    return s == 2'd0 ? d0 : s == 2'd1 ? d1 : s == 2'd2 ? d2 : d3;
  endfunction
  function automatic int unsigned calc_cw(int unsigned d0, int unsigned d1,
                                          int unsigned d2, int unsigned d3);
    int unsigned m01 = d0 > d1 ? d0 : d1;
    int unsigned m23 = d2 > d3 ? d2 : d3;
    return $clog2(m01 > m23 ? m01 : m23);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  assign q = s2_q;
endmodule

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: selectable-rate tick pulse and 50% divided clock; rate changes land on period boundaries.
// Define RATE_TICK_PAUSE_EN to add the synchronised i_pause input that freezes counting.
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter int unsigned DIV0 = 100_000_000,
  parameter int unsigned DIV1 = 50_000_000,
  parameter int unsigned DIV2 = 25_000_000,
  parameter int unsigned DIV3 = 10_000_000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [1:0] contral,
`ifdef RATE_TICK_PAUSE_EN
  input  logic       i_pause,
`endif
  output logic       o_tick,
  output logic       o_CLK
);
  localparam int unsigned CW = calc_cw(DIV0, DIV1, DIV2, DIV3);
  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2 ||
      DIV0 % 2 != 0 || DIV1 % 2 != 0 || DIV2 % 2 != 0 || DIV3 % 2 != 0) begin : g_bad_div
    $error("rate_tick_gen: every DIVn must be even and >= 2");
  end
  rate_sel_t   sel_sync, sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d, d_m1, half_m1;
  logic        tick_q, tick_d, clk_q, clk_d, run, wrap;
  sync_2ff #(.W(2)) u_sel_sync (.clk(CLK), .rst_n(rst_n), .d(contral), .q(sel_sync));
`ifdef RATE_TICK_PAUSE_EN
  logic pause_sync;
  sync_2ff #(.W(1)) u_pause_sync (.clk(CLK), .rst_n(rst_n), .d(i_pause), .q(pause_sync));
  assign run = !pause_sync;
`else
  assign run = 1'b1;
`endif
  // The active rate is only swapped on the wrap, so every period runs at one divisor.
  always_comb begin
    d_m1    = CW'(div_of(sel_q, DIV0, DIV1, DIV2, DIV3) - 1);
    half_m1 = CW'(div_of(sel_q, DIV0, DIV1, DIV2, DIV3) / 2 - 1);
    wrap    = run && cnt_q == d_m1;
    cnt_d   = !run ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
    tick_d  = wrap;
    clk_d   = wrap ? 1'b0 : (run && cnt_q == half_m1) ? 1'b1 : clk_q;
    sel_d   = wrap ? sel_sync : sel_q;
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 2'b00;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  assign o_tick = tick_q;
  assign o_CLK  = clk_q;
endmodule

// File: tb/tb_rate_tick_gen.sv
// tb_rate_tick_gen: randomized and directed checks of rate_tick_gen against a period-position reference model.
module tb_rate_tick_gen;
  logic       CLK = 1'b0, rst_n = 1'b0, i_pause = 1'b0;
  logic [1:0] contral = 2'b00;
  logic       o_tick, o_CLK;
  int total = 0, bad = 0, ncyc = 0, last_tick = 0, gap = 0, hi = 0, last_hi = 0;
  int age = 0, per = 4;
  logic [1:0] s1 = 2'b00, s2 = 2'b00;
  logic p1 = 1'b0, p2 = 1'b0, exp_tick = 1'b0, exp_clk = 1'b0;

  always #5 CLK = ~CLK;

  rate_tick_gen #(.DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10)) dut (
    .CLK(CLK), .rst_n(rst_n), .contral(contral),
`ifdef RATE_TICK_PAUSE_EN
    .i_pause(i_pause),
`endif
    .o_tick(o_tick), .o_CLK(o_CLK)
  );

  function automatic int divof(logic [1:0] s);
    return 4 + 2 * int'(s);
  endfunction

  // Reference: position within the current period; the switch value seen two edges late picks the next period length.
  always @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      age <= 0; per <= 4; s1 <= 2'b00; s2 <= 2'b00; p1 <= 1'b0; p2 <= 1'b0;
      exp_tick <= 1'b0; exp_clk <= 1'b0;
    end else begin
      if (!p2) begin
        if (age == per - 1) begin
          age <= 0; per <= divof(s2); exp_tick <= 1'b1; exp_clk <= 1'b0;
        end else begin
          age <= age + 1; exp_tick <= 1'b0; exp_clk <= (age + 1 >= per / 2);
        end
      end else exp_tick <= 1'b0;
      s1 <= contral; s2 <= s1;
`ifdef RATE_TICK_PAUSE_EN
      p1 <= i_pause; p2 <= p1;
`endif
    end

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, ncyc);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    ncyc++;
    check("tick", int'(o_tick), int'(exp_tick));
    check("oclk", int'(o_CLK), int'(exp_clk));
    if (o_tick) begin
      gap = ncyc - last_tick; last_tick = ncyc; last_hi = hi; hi = 0;
    end else if (o_CLK) hi++;
  endtask

  task automatic wait_tick(input string tag, input int eg, input int eh);
    int n = 0;
    do begin cyc(); n++; end while (!o_tick && n < 40);
    check({tag, "_seen"}, int'(o_tick), 1);
    if (eg >= 0) check({tag, "_gap"}, gap, eg);
    if (eh >= 0) check({tag, "_hi"}, last_hi, eh);
  endtask

  initial begin
    repeat (3) begin
      cyc();
      check("rst_tick", int'(o_tick), 0);
      check("rst_clk", int'(o_CLK), 0);
    end
    rst_n = 1'b1; last_tick = ncyc; hi = 0;
    wait_tick("t1_first", 4, 2);
    repeat (3) wait_tick("t1_per", 4, 2);
    for (int v = 0; v < 4; v++) begin
      contral = 2'(v);
      repeat (2) wait_tick("t2_skip", -1, -1);
      repeat (3) wait_tick($sformatf("t2_sel%0d", v), 4 + 2 * v, 2 + v);
    end
    contral = 2'b00;
    repeat (2) wait_tick("t3_skip", -1, -1);
    wait_tick("t3_base", 4, 2);
    cyc();
    contral = 2'b11;
    wait_tick("t3_old", 4, 2);
    repeat (2) wait_tick("t3_new", 10, 5);
    repeat (3) cyc();
    contral = 2'b00;
    cyc();
    contral = 2'b11;
    repeat (3) wait_tick("t4_glitch", 10, 5);
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_tick", int'(o_tick), 0);
    check("t5_arst_clk", int'(o_CLK), 0);
    repeat (2) cyc();
    rst_n = 1'b1; last_tick = ncyc; hi = 0;
    wait_tick("t5_first", 4, 2);
    wait_tick("t5_next", 10, 5);
`ifdef RATE_TICK_PAUSE_EN
    contral = 2'b00;
    repeat (2) wait_tick("t6_skip", -1, -1);
    i_pause = 1'b1;
    repeat (7) cyc();
    i_pause = 1'b0;
    wait_tick("t6_pause", 11, -1);
    wait_tick("t6_after", 4, 2);
`endif
    repeat (300) begin
      if ($urandom_range(0, 7) == 0) contral = 2'($urandom_range(0, 3));
`ifdef RATE_TICK_PAUSE_EN
      if ($urandom_range(0, 15) == 0) i_pause = ~i_pause;
`endif
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
